// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith/compare/LUI ops and a
// 1-bit-per-cycle iterative shifter, valid/ready on both sides, one op in flight.
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic               shift_v,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               ovf,
    output logic               busy
);

    // state   | meaning
    // S_IDLE  | waiting for a request, in_ready=1
    // S_SHIFT | iterative shift in progress, one bit per cycle
    // S_DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_LUI = 4'b1011;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    state_t              state, state_nxt;
    logic [3:0]          ctrl_q, ctrl_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic [SHAMT_W-1:0]  cnt_q, cnt_nxt;
    logic [DATA_W-1:0]   res_nxt;
    logic                ovf_nxt;
    logic                load_res;

    logic [SHAMT_W-1:0]  amt;
    logic                is_shift;
    logic [DATA_W-1:0]   sum, diff;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_ovf;
    logic [DATA_W-1:0]   shift_in, shift_cur;

    function automatic logic [DATA_W-1:0] shift1(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        case (op)
            OP_SLL:  r = {d[DATA_W-2:0], 1'b0};
            OP_SRL:  r = {1'b0, d[DATA_W-1:1]};
            OP_SRA:  r = {d[DATA_W-1], d[DATA_W-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign amt       = shift_v ? a[SHAMT_W-1:0] : shamt;
    assign is_shift  = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign sum       = a + b;
    assign diff      = a - b;
    // The accepting edge already performs the first shift step.
    assign shift_in  = shift1(alu_ctrl, b);
    assign shift_cur = shift1(ctrl_q, data_q);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_LUI: alu_res = {b[15:0], 16'h0000};
            OP_SLL, OP_SRL, OP_SRA: alu_res = b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ctrl_nxt  = ctrl_q;
        data_nxt  = data_q;
        cnt_nxt   = cnt_q;
        res_nxt   = result;
        ovf_nxt   = ovf;
        load_res  = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ctrl_nxt = alu_ctrl;
                        if (is_shift && (amt != '0)) begin
                            data_nxt = shift_in;
                            cnt_nxt  = amt - 1'b1;
                            if (amt == SHAMT_W'(1)) begin
                                state_nxt = S_DONE;
                                load_res  = 1'b1;
                                res_nxt   = shift_in;
                                ovf_nxt   = 1'b0;
                            end else begin
                                state_nxt = S_SHIFT;
                            end
                        end else begin
                            state_nxt = S_DONE;
                            load_res  = 1'b1;
                            res_nxt   = alu_res;
                            ovf_nxt   = alu_ovf;
                        end
                    end
                end
                S_SHIFT: begin
                    data_nxt = shift_cur;
                    cnt_nxt  = cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_nxt = S_DONE;
                        load_res  = 1'b1;
                        res_nxt   = shift_cur;
                        ovf_nxt   = 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ctrl_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            result <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_nxt;
            data_q <= data_nxt;
            cnt_q  <= cnt_nxt;
            if (load_res) begin
                result <= res_nxt;
                zero   <= (res_nxt == '0);
                ovf    <= ovf_nxt;
            end
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: results, flags, latency, hold,
// flush and asynchronous reset behaviour against hand-computed values.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic        shift_v;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, ovf, busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .shift_v(shift_v), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, measure latency, check outputs, optionally hold, then retire.
    task automatic run_op(input string tag, input logic [3:0] c, input logic sv,
                          input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                          input logic [31:0] er, input logic eo, input int el, input int hold);
        int lat;
        int ir_bad;
        int hold_bad;
        @(negedge clk);
        alu_ctrl = c; shift_v = sv; a = av; b = bv; shamt = sh;
        in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        ir_bad = 0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) ir_bad++;
        end while (!out_valid && lat < 100);
        chk({tag, "_lat"}, 32'(lat), 32'(el));
        chk({tag, "_res"}, result, er);
        chk({tag, "_zero"}, 32'(zero), 32'(er == 32'h0));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        chk({tag, "_in_ready_low"}, 32'(ir_bad), 32'd0);
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || result !== er) hold_bad++;
        end
        if (hold > 0) chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ov_seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = 4'h0; shift_v = 1'b0; a = '0; b = '0; shamt = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf", 4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, 1, 3);
        run_op("sub_zero", 4'b0110, 1'b0, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0, 1, 0);
        run_op("sub_ovf", 4'b0110, 1'b0, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1, 0);
        run_op("slt", 4'b0111, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1, 0);
        run_op("slt_false", 4'b0111, 1'b0, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0, 1, 0);
        run_op("and", 4'b0000, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1, 0);
        run_op("or", 4'b0001, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1, 0);
        run_op("xor", 4'b0011, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0, 1, 0);
        run_op("nor", 4'b1100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F, 1'b0, 1, 0);
        run_op("sra4", 4'b1010, 1'b0, 32'h0, 32'h8000_00F0, 5'd4, 32'hF800_000F, 1'b0, 4, 0);
        run_op("sllv3", 4'b1000, 1'b1, 32'h0000_0023, 32'h1, 5'd0, 32'h8, 1'b0, 3, 0);
        run_op("srl0", 4'b1001, 1'b0, 32'h0, 32'hABCD_0000, 5'd0, 32'hABCD_0000, 1'b0, 1, 0);
        run_op("srl1", 4'b1001, 1'b0, 32'h0, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b0, 1, 0);
        run_op("sllv31", 4'b1000, 1'b1, 32'hFFFF_FFFF, 32'h1, 5'd9, 32'h8000_0000, 1'b0, 31, 0);
        run_op("sra31", 4'b1010, 1'b0, 32'h0, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 31, 0);
        run_op("lui", 4'b1011, 1'b0, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1, 0);
        run_op("undef", 4'b0101, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 32'h0, 1'b0, 1, 0);
        run_op("add_pre_flush", 4'b0010, 1'b0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1, 0);

        // Flush in the second cycle of SLL by 10.
        @(negedge clk);
        alu_ctrl = 4'b1000; shift_v = 1'b0; a = '0; b = 32'h1; shamt = 5'd10; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("flush_no_valid", 32'(ov_seen), 32'd0);
        chk("flush_result_kept", result, 32'd5);

        // Flush beats acceptance in IDLE.
        @(negedge clk);
        alu_ctrl = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_accept", 32'(busy), 32'd0);

        // Asynchronous reset mid-SHIFT.
        @(negedge clk);
        alu_ctrl = 4'b1000; shift_v = 1'b0; b = 32'h1; shamt = 5'd10; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_result", result, 32'h0);
        chk("arst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_add", 4'b0010, 1'b0, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
